pattern_reader_8x2: RTL and testbench
=====================================

PATTERN_READER_8X2 -- requirements
Module: pattern_reader_8x2

Interface
REQ-001 SHALL provide parameter STEP_CYCLES, default 4: clock cycles each slot is held on the output; legal range 1..255.
REQ-002 SHALL provide port clk  input  1  rising-edge system clock.
REQ-003 SHALL provide port rst  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-004 SHALL provide ports reg_in0..reg_in7  input  2 each  stored pattern slots 0..7 from the pattern writer.
REQ-005 SHALL provide port ready  input  1  high when all eight slots are valid, driven by the writer's done.
REQ-006 SHALL provide port start  input  1  single-cycle request to begin playback.
REQ-007 SHALL provide port stop  input  1  abort playback.
REQ-008 SHALL provide port led_code  output  2  code of the slot currently playing, registered.
REQ-009 SHALL provide port led  output  4  one-hot decode of led_code.
REQ-010 SHALL provide port slot_idx  output  3  index of the slot currently playing.
REQ-011 SHALL provide port busy  output  1  high while playback is active.
REQ-012 SHALL provide port play_done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 SHALL implement FSM states IDLE, PLAY, DONE.
REQ-014 IDLE: busy=0, led_code=0, led=0, slot_idx=0, play_done=0.
REQ-015 IDLE, start=1 and ready=1 at edge k: snapshot reg_in0..7 into an internal 16-bit buffer, go to PLAY, load led_code=reg_in0 and slot_idx=0, clear the prescaler.
REQ-016 IDLE, start=1 with ready=0: ignore start and remain in IDLE.
REQ-017 PLAY: hold each slot exactly STEP_CYCLES cycles, so slot n is output in cycles k+1+n*STEP_CYCLES .. k+(n+1)*STEP_CYCLES.
REQ-018 PLAY: when the prescaler reaches STEP_CYCLES-1, clear it, increment slot_idx, and load led_code from buffer slot slot_idx+1.
REQ-019 PLAY: the output SHALL come only from the snapshot; changes on reg_in* or ready during PLAY SHALL have no effect.
REQ-020 PLAY, last cycle of slot 7: go to DONE.
REQ-021 DONE: play_done=1, busy=0, led_code=0, led=0 for exactly one cycle (cycle k+8*STEP_CYCLES+1), then go to IDLE.
REQ-022 PLAY, start=1: ignore it, with no restart and no snapshot.
REQ-023 PLAY, stop=1: go to IDLE on the next edge with led_code=0 and no play_done pulse; stop SHALL take priority over slot advance and completion in the same cycle.
REQ-024 IDLE or DONE, stop=1: no effect; start+stop together in IDLE SHALL begin playback.
REQ-025 DONE, start=1: ignore it; a new start is accepted only in IDLE.
REQ-026 led SHALL equal 4'b0001 shifted left by led_code while busy=1, and 4'b0000 otherwise.
REQ-027 slot_idx SHALL be 3 bits, and the prescaler 8 bits, compared against STEP_CYCLES-1; STEP_CYCLES=1 advances one slot per cycle.

Reset
REQ-028 When rst=0 at an edge, the block SHALL enter IDLE and clear all outputs, the buffer, the prescaler and slot_idx, regardless of state; reset mid-PLAY SHALL produce no play_done.
REQ-029 The block SHALL have no asynchronous reset path; outputs SHALL take reset values one edge after rst is sampled low.

Configuration
REQ-030 Macro PATTERN_LOOP_EN, defined: adds port loop (input, 1), and loop=1 at the last cycle of slot 7 SHALL wrap to slot 0 of the same snapshot with no DONE and no play_done; stop still aborts.
REQ-031 Macro PATTERN_LOOP_EN, undefined: port loop SHALL be absent and behaviour SHALL be as loop=0.

Verification
REQ-032 STEP_CYCLES=4, slots 3,2,1,0,3,2,1,0, ready=1, start pulse -> led_code 3,2,1,0,3,2,1,0, each held 4 cycles, and led 1000,0100,0010,0001 repeating; play_done pulses at cycle 33 after start; busy high for 32 cycles.
REQ-033 ready=0, start pulse -> stays in IDLE, busy=0, led=0 for 40 cycles; then ready=1 plus start -> normal playback.
REQ-034 Start playback, set stop=1 at slot_idx=5 -> next cycle busy=0, led_code=0, no play_done; a later start replays from slot 0.
REQ-035 Start playback, then change all reg_in* to 0 and pulse start at slot_idx=2 -> playback continues with the original snapshot and no restart.
REQ-036 rst=0 at slot_idx=3 -> all outputs 0 next cycle and no play_done; with PATTERN_LOOP_EN, loop=1 -> slot 7 followed by slot 0, and play_done never asserts.

Source files
------------

// File: rtl/pattern_reader_8x2.sv
// -----------------------------------------------------------------------------
// pattern_reader_8x2
//
// Plays back an eight-slot, 2-bit-per-slot pattern on a one-hot LED bus.
// On an accepted start the eight slots are copied into a private snapshot.
// Each slot is then shown for STEP_CYCLES clock cycles. A one-cycle
// play_done pulse marks normal completion. Later writes to the pattern
// inputs cannot disturb a playback that is already running.
//
// Optional feature (macro PATTERN_LOOP_EN):
//   When defined, an extra input `loop` is present. loop=1 in the last cycle
//   of slot 7 wraps back to slot 0 of the same snapshot instead of finishing.
//   When undefined, the port is absent and playback always finishes.
//
// Parameters
//   STEP_CYCLES  cycles each slot is held on the output (1..255)
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous reset, active low
//   reg_in0..reg_in7  pattern slots 0..7 from the pattern writer
//   ready             all eight slots valid (writer's done)
//   start             single-cycle playback request (honoured in IDLE only)
//   stop              abort playback (honoured in PLAY only)
//   loop              wrap request (PATTERN_LOOP_EN builds only)
//   led_code          code of the slot currently playing (registered)
//   led               one-hot decode of led_code while busy, else 0
//   slot_idx          index of the slot currently playing
//   busy              high while playback is active
//   play_done         one-cycle pulse on normal completion
//   state_dbg         current FSM state (IDLE=0, PLAY=1, DONE=2)
//
// Handshake: start is a level sampled on a rising edge. It is accepted only
// when the FSM is in IDLE and ready=1 at that same edge. There is no
// acknowledge. busy rising on the following cycle confirms acceptance.
// stop is sampled the same way and only acts while busy=1.
// -----------------------------------------------------------------------------
module pattern_reader_8x2 #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] reg_in0,
  input  logic [1:0] reg_in1,
  input  logic [1:0] reg_in2,
  input  logic [1:0] reg_in3,
  input  logic [1:0] reg_in4,
  input  logic [1:0] reg_in5,
  input  logic [1:0] reg_in6,
  input  logic [1:0] reg_in7,
  input  logic       ready,
  input  logic       start,
  input  logic       stop,
`ifdef PATTERN_LOOP_EN
  input  logic       loop,
`endif
  output logic [1:0] led_code,
  output logic [3:0] led,
  output logic [2:0] slot_idx,
  output logic       busy,
  output logic       play_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Prescaler terminal value. The prescaler runs 0..PRESC_LAST within a slot.
  localparam logic [7:0] PRESC_LAST = 8'(STEP_CYCLES - 1);

  state_t      state;
  logic [15:0] snap;    // slot n lives in snap[2n+1:2n]
  logic [7:0]  presc;

  logic [15:0] pattern_in;
  logic [2:0]  nxt_slot;
  logic [1:0]  nxt_code;
  logic        slot_last;
  logic        loop_en;

  assign pattern_in = {reg_in7, reg_in6, reg_in5, reg_in4,
                       reg_in3, reg_in2, reg_in1, reg_in0};

`ifdef PATTERN_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // slot_idx+1 wraps 7 -> 0 naturally. The loop wrap therefore reads slot 0
  // of the snapshot without any special case.
  assign nxt_slot  = slot_idx + 3'd1;
  assign nxt_code  = snap[{nxt_slot, 1'b0} +: 2];
  assign slot_last = (presc == PRESC_LAST);

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      snap      <= '0;
      presc     <= '0;
      slot_idx  <= '0;
      led_code  <= '0;
      led       <= '0;
      busy      <= 1'b0;
      play_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          play_done <= 1'b0;
          presc     <= '0;
          slot_idx  <= '0;
          // A concurrent stop is meaningless here, so start wins.
          if (start && ready) begin
            state    <= PLAY;
            snap     <= pattern_in;
            led_code <= reg_in0;
            led      <= 4'b0001 << reg_in0;
            busy     <= 1'b1;
          end else begin
            led_code <= '0;
            led      <= '0;
            busy     <= 1'b0;
          end
        end

        PLAY: begin
          // Stop outranks slot advance and completion in the same cycle.
          // start is deliberately ignored here, so there is no restart.
          if (stop) begin
            state     <= IDLE;
            presc     <= '0;
            slot_idx  <= '0;
            led_code  <= '0;
            led       <= '0;
            busy      <= 1'b0;
            play_done <= 1'b0;
          end else if (slot_last) begin
            presc <= '0;
            if (slot_idx == 3'd7 && !loop_en) begin
              state     <= DONE;
              slot_idx  <= '0;
              led_code  <= '0;
              led       <= '0;
              busy      <= 1'b0;
              play_done <= 1'b1;
            end else begin
              slot_idx <= nxt_slot;
              led_code <= nxt_code;
              led      <= 4'b0001 << nxt_code;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end

        DONE: begin
          // Single completion cycle. start and stop are both ignored.
          state     <= IDLE;
          play_done <= 1'b0;
          presc     <= '0;
          slot_idx  <= '0;
          led_code  <= '0;
          led       <= '0;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          presc     <= '0;
          slot_idx  <= '0;
          led_code  <= '0;
          led       <= '0;
          busy      <= 1'b0;
          play_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_reader_8x2.sv
// -----------------------------------------------------------------------------
// tb_pattern_reader_8x2
//
// Bench for pattern_reader_8x2 with STEP_CYCLES=4, plus a STEP_CYCLES=1 copy.
//
// A reference model tracks playback as "elapsed cycles since the start edge".
// From that count it derives slot = elapsed / STEP and code = snapshot[slot].
// The model pushes one packed expected output word per cycle onto exp_q.
// -----------------------------------------------------------------------------
module tb_pattern_reader_8x2;

  localparam int S   = 4;
  localparam int RUN = 8 * S + 10;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] r [8];
  logic       ready, start, stop;
`ifdef PATTERN_LOOP_EN
  logic       loop;
`endif
  logic [1:0] led_code;
  logic [3:0] led;
  logic [2:0] slot_idx;
  logic       busy, play_done;
  logic [1:0] state_dbg;

  logic [1:0] u1_code;
  logic [3:0] u1_led;
  logic [2:0] u1_slot;
  logic       u1_busy, u1_done;
  logic [1:0] u1_state;

  pattern_reader_8x2 #(.STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .reg_in0(r[0]), .reg_in1(r[1]), .reg_in2(r[2]), .reg_in3(r[3]),
    .reg_in4(r[4]), .reg_in5(r[5]), .reg_in6(r[6]), .reg_in7(r[7]),
    .ready(ready), .start(start), .stop(stop),
`ifdef PATTERN_LOOP_EN
    .loop(loop),
`endif
    .led_code(led_code), .led(led), .slot_idx(slot_idx),
    .busy(busy), .play_done(play_done), .state_dbg(state_dbg)
  );

  pattern_reader_8x2 #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .reg_in0(r[0]), .reg_in1(r[1]), .reg_in2(r[2]), .reg_in3(r[3]),
    .reg_in4(r[4]), .reg_in5(r[5]), .reg_in6(r[6]), .reg_in7(r[7]),
    .ready(ready), .start(start), .stop(stop),
`ifdef PATTERN_LOOP_EN
    .loop(loop),
`endif
    .led_code(u1_code), .led(u1_led), .slot_idx(u1_slot),
    .busy(u1_busy), .play_done(u1_done), .state_dbg(u1_state)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model
  logic [1:0] m_snap [8];
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_el     = 0;

  function automatic bit loop_v();
`ifdef PATTERN_LOOP_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int         sl;
    logic [1:0] code;
    if (!rst) begin
      m_active = 0; m_done = 0; m_el = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && ready) begin
        for (int i = 0; i < 8; i++) m_snap[i] = r[i];
        m_active = 1; m_el = 0;
      end
    end else if (stop) begin
      m_active = 0;
    end else begin
      m_el++;
      if (m_el == 8 * S) begin
        if (loop_v()) m_el = 0;
        else begin m_active = 0; m_done = 1; end
      end
    end
    sl   = m_active ? m_el / S : 0;
    code = m_active ? m_snap[sl] : 2'd0;
    exp_q.push_back({m_active, 3'(sl), code,
                     m_active ? (4'b0001 << code) : 4'b0000, m_done});
  endtask

  task automatic compare_outputs();
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("outputs{busy,slot,code,led,done}",
            32'({busy, slot_idx, led_code, led, play_done}), 32'(e));
    end
  endtask

  // driver: inputs change on negedge, DUT and model see them at posedge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic set_pattern(input logic [15:0] p);
    for (int i = 0; i < 8; i++) r[i] = p[2*i +: 2];
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_slot(input int target);
    bit found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (busy && slot_idx == 3'(target)) found = 1;
      else cycle();
    end
    check($sformatf("wait_slot_%0d", target), 32'(found), 32'd1);
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (play_done) cnt++;
    end
  endtask

  // table of playback vectors
  typedef struct packed {
    logic [15:0] pat;
    logic        rdy;
    logic [15:0] exp_codes;  // led_code observed in slots 0..7
    logic        exp_done;
  } vec_t;

  vec_t vec [5];

  initial begin
    int cnt;
    int done_j, d1_j;
    logic [15:0] obs, obs1;

    vec[0] = '{pat: 16'h1B1B, rdy: 1'b1, exp_codes: 16'h1B1B, exp_done: 1'b1};
    vec[1] = '{pat: 16'hFFFF, rdy: 1'b0, exp_codes: 16'h0000, exp_done: 1'b0};
    vec[2] = '{pat: 16'hE4E4, rdy: 1'b1, exp_codes: 16'hE4E4, exp_done: 1'b1};
    vec[3] = '{pat: 16'h0000, rdy: 1'b1, exp_codes: 16'h0000, exp_done: 1'b1};
    vec[4] = '{pat: 16'hA5C3, rdy: 1'b1, exp_codes: 16'hA5C3, exp_done: 1'b1};

    rst = 1'b0; ready = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef PATTERN_LOOP_EN
    loop = 1'b0;
`endif
    set_pattern(16'h0000);
    @(negedge clk);

    // reset state
    for (int i = 0; i < 3; i++) cycle();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    rst = 1'b1;
    cycle();

    // table-driven playback. Inputs are scrambled during playback.
    for (int t = 0; t < 5; t++) begin
      set_pattern(vec[t].pat);
      ready = vec[t].rdy;
      start_pulse();
      obs = '0; obs1 = '0; done_j = -1; d1_j = -1; cnt = 0;
      for (int j = 1; j <= RUN; j++) begin
        if (j <= 8 * S && (j - 1) % S == 0) obs[2*((j-1)/S) +: 2] = led_code;
        if (j <= 8) obs1[2*(j-1) +: 2] = u1_code;
        if (play_done) begin cnt++; done_j = j; end
        if (u1_done) d1_j = j;
        if (j < RUN) begin
          for (int i = 0; i < 8; i++) r[i] = 2'($urandom_range(0, 3));
          ready = 1'($urandom_range(0, 1));
          cycle();
        end
      end
      check($sformatf("vec%0d_codes", t), 32'(obs), 32'(vec[t].exp_codes));
      check($sformatf("vec%0d_done_count", t), 32'(cnt), 32'(vec[t].exp_done));
      check($sformatf("vec%0d_done_cycle", t), 32'(done_j),
            vec[t].exp_done ? 32'(8 * S + 1) : 32'hFFFF_FFFF);
      check($sformatf("vec%0d_s1_codes", t), 32'(obs1), 32'(vec[t].exp_codes));
      check($sformatf("vec%0d_s1_done_cycle", t), 32'(d1_j),
            vec[t].exp_done ? 32'd9 : 32'hFFFF_FFFF);
    end

    // stop at slot 5, then replay from slot 0
    set_pattern(16'h1B1B); ready = 1'b1;
    start_pulse();
    wait_slot(5);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_code", 32'(led_code), 32'd0);
    check("stop_done", 32'(play_done), 32'd0);
    run_count(40, cnt);
    check("stop_no_done", 32'(cnt), 32'd0);
    start_pulse();
    check("restart_slot", 32'(slot_idx), 32'd0);
    check("restart_code", 32'(led_code), 32'd3);
    stop = 1'b1; cycle(); stop = 1'b0;

    // snapshot isolation and start ignored during PLAY
    set_pattern(16'h1B1B);
    start_pulse();
    wait_slot(2);
    set_pattern(16'h0000);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_slot(4);
    check("snap_slot4_code", 32'(led_code), 32'd3);
    run_count(40, cnt);
    check("snap_done_once", 32'(cnt), 32'd1);

    // reset in the middle of playback
    set_pattern(16'h1B1B);
    start_pulse();
    wait_slot(3);
    rst = 1'b0;
    cycle();
    check("midrst_outs", 32'({busy, slot_idx, led_code, led, play_done}), 32'd0);
    rst = 1'b1;
    run_count(40, cnt);
    check("midrst_no_done", 32'(cnt), 32'd0);

`ifdef PATTERN_LOOP_EN
    // loop wrap: slot 7 is followed by slot 0 and play_done never fires
    loop = 1'b1;
    start_pulse();
    wait_slot(7);
    for (int i = 0; i < S; i++) cycle();
    check("loop_wrap_slot", 32'(slot_idx), 32'd0);
    check("loop_wrap_busy", 32'(busy), 32'd1);
    run_count(80, cnt);
    check("loop_no_done", 32'(cnt), 32'd0);
    stop = 1'b1; cycle(); stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);
    loop = 1'b0;
`endif

    // randomized phase against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 8; i++) r[i] = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) != 0);
`ifdef PATTERN_LOOP_EN
      loop  = 1'($urandom_range(0, 1));
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
